reverse_stream: RTL and testbench
=================================

Name: reverse_stream

Overview:
Frame-order reversal buffer: accepts a frame of words on a valid/ready stream and replays the words last-first on an output stream. This is the temporal counterpart of bit-order reversal within a bus. Typical uses are undoing LSB/MSB-first word ordering from serial links and feeding LIFO-ordered data to bit-reversed FFT stages. It sits between two valid/ready stream stages and holds one frame at a time: fill, then drain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, maximum frame length in words (>=2); storage is DEPTH x WIDTH registers
CNT_W, $clog2(DEPTH+1), width of length/pointer counters (localparam, not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
s_data  input  WIDTH  input word
s_valid  input  1  input word valid
s_last  input  1  marks final word of input frame
s_ready  output  1  block can accept a word this cycle
m_data  output  WIDTH  output word
m_valid  output  1  output word valid
m_last  output  1  marks final output word (= first word received)
m_ready  input  1  downstream accepts word this cycle
frame_len  output  CNT_W  number of words in frame being drained; 0 while filling
trunc  output  1  one-cycle pulse: frame force-closed at DEPTH words without s_last

Behaviour:
- States: FILL, DRAIN. Reset -> FILL, wr_cnt=0, rd_ptr=0.
- Reset values: s_ready=1 from the first cycle after reset (0 while rst is high), m_valid=0, m_last=0, m_data=0, frame_len=0, trunc=0.
- FILL:
  - s_ready=1, m_valid=0.
  - Accept: s_valid && s_ready. The word is written to mem[wr_cnt], then wr_cnt++.
  - Frame close: an accepted word with s_last=1, or the accepted word making wr_cnt==DEPTH.
  - On close, next state is DRAIN, with frame_len=wr_cnt+1 and rd_ptr=wr_cnt (index of the closing word).
  - If the close was due to DEPTH without s_last, trunc=1 for that next cycle only.
  - Further words belong to the next frame; nothing is dropped.
- DRAIN:
  - s_ready=0, m_valid=1.
  - m_data=mem[rd_ptr], driven combinationally from storage (register array, no read latency); m_data=0 whenever m_valid=0.
  - m_last=1 iff rd_ptr==0.
  - Transfer: m_valid && m_ready. If rd_ptr!=0 then rd_ptr--. If rd_ptr==0, next state is FILL, with wr_cnt=0 and frame_len=0.
  - m_valid/m_data/m_last hold stable while m_ready=0 (AXI-stream rules).
- Latency: the first output word is valid in the cycle after the closing input word is accepted. A frame of N words occupies N input cycles + N output transfers. There is no overlap: s_ready is 0 throughout DRAIN and returns to 1 in the cycle after the m_last transfer.
- Single-word frame (s_last on first word): DRAIN with rd_ptr=0, m_last=1 on the only output word, frame_len=1.
- s_last together with reaching DEPTH: normal close, trunc stays 0.
- s_data/s_last are ignored when s_valid=0. m_ready is ignored in FILL.
- rst mid-FILL or mid-DRAIN: the partial/pending frame is discarded. The next cycle is in FILL with all outputs at reset values. Storage contents need not be cleared.
- wr_cnt never exceeds DEPTH; rd_ptr never wraps below 0.

Test Plan:
- DEPTH=16, WIDTH=8, frame 0x11,0x22,0x33,0x44 (s_last on 0x44), m_ready=1 -> output 0x44,0x33,0x22,0x11 on 4 consecutive cycles. First m_valid is the cycle after 0x44 is accepted, m_last only with 0x11, frame_len=4, s_ready=0 during drain and 1 the cycle after.
- Single word 0xA5 with s_last -> one output 0xA5 with m_last=1, frame_len=1, back to FILL next cycle.
- DEPTH=4, input 1,2,3,4,5,6 with s_last only on 6 -> trunc pulse once, output 4,3,2,1 (m_last on 1), then output 6,5 (m_last on 5, trunc stays 0).
- Backpressure: 3-word frame 0x0A,0x0B,0x0C, m_ready pattern 0,1,0,0,1,1 -> outputs held stable while m_ready=0, with sequence 0x0C,0x0B,0x0A delivered exactly once each.
- Reset mid-drain: 5-word frame, assert rst after 2 output transfers -> next cycle m_valid=0, s_ready=1, frame_len=0. A new 2-word frame 0x01,0x02 then drains as 0x02,0x01.
- Back-to-back frames with s_valid held high: s_ready deasserts during each drain, no word is lost or duplicated, and each frame is reversed independently.

Source files
------------

// File: rtl/reverse_stream_if.sv
// Valid/ready word stream carrying a frame delimiter; master drives data, slave drives ready.
interface reverse_stream_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             last;
   logic             ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/reverse_stream.sv
// Frame-order reversal buffer: fills one frame of words, then replays it last-first.
module reverse_stream #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   reverse_stream_if.slave   s,
   reverse_stream_if.master  m,
   output logic [CNT_W-1:0]  frame_len,
   output logic              trunc
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] frame_len_d;
   logic             trunc_d;
   logic             wr_en;
   logic             accept;
   logic             xfer;
   logic [WIDTH-1:0] mem [DEPTH];

   // Handshake and read side decode straight from state; no read latency on storage.
   assign s.ready = (state_q == FILL) && !rst;
   assign m.valid = (state_q == DRAIN);
   assign m.last  = (state_q == DRAIN) && (rd_ptr_q == '0);
   assign m.data  = (state_q == DRAIN) ? mem[rd_ptr_q[AW-1:0]] : '0;

   assign accept = s.valid && s.ready;
   assign xfer   = m.valid && m.ready;

   // Next-state logic: a frame closes on s_last or when the last free slot is written.
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      frame_len_d = frame_len;
      trunc_d     = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
               if (s.last || (wr_cnt_q == CNT_W'(DEPTH - 1))) begin
                  state_d     = DRAIN;
                  frame_len_d = wr_cnt_q + CNT_W'(1);
                  rd_ptr_d    = wr_cnt_q;
                  trunc_d     = !s.last;
               end
            end
         end
         DRAIN: begin
            if (xfer) begin
               if (rd_ptr_q == '0) begin
                  state_d     = FILL;
                  wr_cnt_d    = '0;
                  frame_len_d = '0;
               end else begin
                  rd_ptr_d = rd_ptr_q - CNT_W'(1);
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         wr_cnt_q  <= '0;
         rd_ptr_q  <= '0;
         frame_len <= '0;
         trunc     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         frame_len <= frame_len_d;
         trunc     <= trunc_d;
      end
   end

   // Frame storage; contents survive reset since a new frame overwrites from slot 0.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_cnt_q[AW-1:0]] <= s.data;
      end
   end
endmodule

// File: tb/tb_reverse_stream.sv
// Bench for reverse_stream: DEPTH=16 and DEPTH=4 instances, each checked against a queue model.
module tb_reverse_stream;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_data  [2];
   logic       s_valid [2];
   logic       s_last  [2];
   logic       m_ready [2];
   int         pin_checks = 0;
   int         pin_errs   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int D  = (gi == 0) ? 16 : 4;
      localparam int CW = $clog2(D + 1);

      reverse_stream_if #(.WIDTH(8)) s_if ();
      reverse_stream_if #(.WIDTH(8)) m_if ();
      logic [CW-1:0] frame_len;
      logic          trunc;

      assign s_if.data  = s_data[gi];
      assign s_if.valid = s_valid[gi];
      assign s_if.last  = s_last[gi];
      assign m_if.ready = m_ready[gi];

      reverse_stream #(.WIDTH(8), .DEPTH(D)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .s         (s_if),
         .m         (m_if),
         .frame_len (frame_len),
         .trunc     (trunc)
      );

      // Model: collect words, reverse the whole frame at close, pop one per transfer.
      logic [7:0] fill_q  [$];
      logic [7:0] exp_q   [$];
      logic [7:0] out_log [$];
      bit         drain      = 1'b0;
      bit         trunc_exp  = 1'b0;
      int         flen       = 0;
      int         checks     = 0;
      int         errors     = 0;
      int         trunc_seen = 0;

      task automatic chk(input string name, input int act, input int exp);
         checks++;
         if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s at %0t: got 0x%0h, required 0x%0h", gi, name, $time, act, exp);
         end
      endtask

      always @(negedge clk) begin
         if (rst) begin
            chk("s_ready_in_reset", int'(s_if.ready), 0);
            drain     = 1'b0;
            trunc_exp = 1'b0;
            flen      = 0;
            fill_q.delete();
            exp_q.delete();
         end else begin
            chk("s_ready",   int'(s_if.ready),  int'(!drain));
            chk("m_valid",   int'(m_if.valid),  int'(drain));
            chk("m_last",    int'(m_if.last),   int'(drain && exp_q.size() == 1));
            chk("m_data",    int'(m_if.data),   drain ? int'(exp_q[0]) : 0);
            chk("frame_len", int'(frame_len),   flen);
            chk("trunc",     int'(trunc),       int'(trunc_exp));
            if (trunc) trunc_seen++;
            trunc_exp = 1'b0;
            if (!drain) begin
               if (s_valid[gi]) begin
                  fill_q.push_back(s_data[gi]);
                  if (s_last[gi] || fill_q.size() == D) begin
                     trunc_exp = !s_last[gi];
                     flen      = fill_q.size();
                     exp_q.delete();
                     for (int k = fill_q.size() - 1; k >= 0; k--) exp_q.push_back(fill_q[k]);
                     fill_q.delete();
                     drain = 1'b1;
                  end
               end
            end else if (m_ready[gi]) begin
               out_log.push_back(exp_q[0]);
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  drain = 1'b0;
                  flen  = 0;
               end
            end
         end
      end
   end

   function automatic int log_size(input int i);
      return (i == 0) ? g_dut[0].out_log.size() : g_dut[1].out_log.size();
   endfunction

   function automatic bit model_drain(input int i);
      return (i == 0) ? g_dut[0].drain : g_dut[1].drain;
   endfunction

   function automatic bit dut_ready(input int i);
      return (i == 0) ? g_dut[0].s_if.ready : g_dut[1].s_if.ready;
   endfunction

   // Present one word and hold it until the DUT takes it.
   task automatic send(input int i, input logic [7:0] d, input bit l);
      bit r = 1'b0;
      int n = 0;
      s_data[i]  = d;
      s_valid[i] = 1'b1;
      s_last[i]  = l;
      do begin
         @(negedge clk);
         r = dut_ready(i);
         @(posedge clk);
         #1;
         n++;
      end while (!r && n < 200);
      if (!r) begin
         pin_checks++;
         pin_errs++;
         $display("FAIL send_timeout dut%0d word 0x%0h: ready 0, required 1 within 200 cycles", i, d);
      end
   endtask

   task automatic idle(input int i);
      s_valid[i] = 1'b0;
      s_last[i]  = 1'b0;
   endtask

   task automatic wait_drain(input int i);
      int n = 0;
      while (model_drain(i) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (model_drain(i)) begin
         pin_checks++;
         pin_errs++;
         $display("FAIL drain_timeout dut%0d: still draining, required idle within 100 cycles", i);
      end
   endtask

   task automatic pin_log(input int i, input int start, input string name, input logic [7:0] e[$]);
      logic [7:0] q[$];
      bit ok;
      if (i == 0) q = g_dut[0].out_log;
      else        q = g_dut[1].out_log;
      ok = ((q.size() - start) == e.size());
      for (int k = 0; ok && k < e.size(); k++) if (q[start + k] != e[k]) ok = 1'b0;
      pin_checks++;
      if (!ok) begin
         pin_errs++;
         $display("FAIL %s: got %p from offset %0d, required %p", name, q, start, e);
      end
   endtask

   task automatic pin_int(input string name, input int act, input int exp);
      pin_checks++;
      if (act != exp) begin
         pin_errs++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   initial begin
      logic [7:0] e[$];
      int st;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_data[i]  = 8'h00;
         s_valid[i] = 1'b0;
         s_last[i]  = 1'b0;
         m_ready[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Four-word frame, free-flowing output.
      st = log_size(0);
      send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b0); send(0, 8'h44, 1'b1);
      idle(0);
      wait_drain(0);
      e = '{8'h44, 8'h33, 8'h22, 8'h11};
      pin_log(0, st, "four_word_order", e);

      // Single-word frame.
      st = log_size(0);
      send(0, 8'hA5, 1'b1);
      idle(0);
      wait_drain(0);
      e = '{8'hA5};
      pin_log(0, st, "single_word", e);

      // Truncation at DEPTH=4, remaining words form the next frame.
      st = log_size(1);
      for (int k = 1; k <= 6; k++) send(1, 8'(k), k == 6);
      idle(1);
      wait_drain(1);
      e = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h06, 8'h05};
      pin_log(1, st, "trunc_split_order", e);
      pin_int("trunc_pulse_count_d4", g_dut[1].trunc_seen, 1);

      // Backpressure pattern during drain.
      st = log_size(0);
      m_ready[0] = 1'b0;
      send(0, 8'h0A, 1'b0); send(0, 8'h0B, 1'b0); send(0, 8'h0C, 1'b1);
      idle(0);
      begin
         bit pat[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         for (int k = 0; k < 6; k++) begin
            m_ready[0] = pat[k];
            @(posedge clk);
            #1;
         end
      end
      m_ready[0] = 1'b1;
      wait_drain(0);
      e = '{8'h0C, 8'h0B, 8'h0A};
      pin_log(0, st, "backpressure_order", e);

      // Reset after two transfers of a five-word frame, then a fresh frame.
      st = log_size(0);
      for (int k = 1; k <= 5; k++) send(0, 8'(8'h60 + k), k == 5);
      idle(0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      pin_int("drain_after_reset", int'(model_drain(0)), 0);
      send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b1);
      idle(0);
      wait_drain(0);
      e = '{8'h65, 8'h64, 8'h02, 8'h01};
      pin_log(0, st, "reset_mid_drain", e);

      // Back-to-back frames with s_valid held high throughout.
      st = log_size(0);
      send(0, 8'h31, 1'b0); send(0, 8'h32, 1'b0); send(0, 8'h33, 1'b1);
      send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b1);
      send(0, 8'h51, 1'b1);
      idle(0);
      wait_drain(0);
      e = '{8'h33, 8'h32, 8'h31, 8'h42, 8'h41, 8'h51};
      pin_log(0, st, "back_to_back", e);
      pin_int("trunc_pulse_count_d16", g_dut[0].trunc_seen, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors",
               g_dut[0].checks + g_dut[1].checks + pin_checks,
               g_dut[0].errors + g_dut[1].errors + pin_errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end
endmodule
